// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer and the memory stage that consumes
// its controls: request opcodes, sequencer states, write-source and
// address-select codes.
package stack_seq_pkg;

    // Request opcodes from the execute side; codes 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CALL = 3'd1,
        OP_RET  = 3'd2,
        OP_INT  = 3'd3,
        OP_RTI  = 3'd4
    } op_e;

    // One state per memory cycle of a sequence.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_FLAGS = 3'd1,
        ST_PUSH_HI    = 3'd2,
        ST_PUSH_LO    = 3'd3,
        ST_POP_LO     = 3'd4,
        ST_POP_HI     = 3'd5,
        ST_POP_FLAGS  = 3'd6
    } state_e;

    // Memory write-data source select.
    localparam logic [1:0] WSRC_FLAGS = 2'b00;
    localparam logic [1:0] WSRC_PC_HI = 2'b01;
    localparam logic [1:0] WSRC_PC_LO = 2'b10;
    localparam logic [1:0] WSRC_REG   = 2'b11;

    // Memory address select.
    localparam logic [1:0] ADDR_STD = 2'b00;
    localparam logic [1:0] ADDR_LDD = 2'b01;
    localparam logic [1:0] ADDR_SP  = 2'b10;

    // True for the four opcodes that launch a sequence.
    function automatic logic op_is_sequence(input logic [2:0] code);
        return (code == OP_CALL) || (code == OP_RET) ||
               (code == OP_INT)  || (code == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-cycle CALL/RET/INT/RTI sequencer in front of the memory stage.
// Emits per-cycle push/pop and select controls, stalls upstream while busy
// and injects latched external interrupts as INT sequences when idle.
module stack_sequencer
    import stack_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       irq,
    output logic       memory_read,
    output logic       memory_write,
    output logic       memory_push,
    output logic       memory_pop,
    output logic [1:0] memory_write_src_select,
    output logic [1:0] memory_address_select,
    output logic       pc_choose_memory,
    output logic       interrupt,
    output logic       flags_restore,
    output logic       stall,
    output logic       done
);

    state_e state_q, state_d;
    logic   irq_pending_q, irq_pending_d;
    logic   seq_is_int_q, seq_is_int_d;
    logic   seq_is_rti_q, seq_is_rti_d;

    logic   idle;
    logic   accept_start;
    logic   accept_irq;

    // A request is only taken in IDLE; an explicit start outranks a pending irq.
    // Reset gates acceptance so every output, stall included, is 0 during reset.
    assign idle         = (state_q == ST_IDLE);
    assign accept_start = idle && !reset && start && op_is_sequence(op);
    assign accept_irq   = idle && !reset && !accept_start && irq_pending_q;

    // Next-state logic: sequence walk, interrupt latching and sequence-type capture.
    always_comb begin
        state_d      = state_q;
        seq_is_int_d = seq_is_int_q;
        seq_is_rti_d = seq_is_rti_q;
        // irq is latched on any cycle; accepting an INT clears it below, so an
        // irq coinciding with start+INT is served by that same INT.
        irq_pending_d = irq_pending_q | irq;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) begin
                    seq_is_int_d = (op == OP_INT);
                    seq_is_rti_d = (op == OP_RTI);
                    case (op)
                        OP_CALL: state_d = ST_PUSH_HI;
                        OP_INT: begin
                            state_d       = ST_PUSH_FLAGS;
                            irq_pending_d = 1'b0;
                        end
                        default: state_d = ST_POP_LO;
                    endcase
                end else if (accept_irq) begin
                    state_d       = ST_PUSH_FLAGS;
                    seq_is_int_d  = 1'b1;
                    seq_is_rti_d  = 1'b0;
                    irq_pending_d = 1'b0;
                end
            end
            ST_PUSH_FLAGS: state_d = ST_PUSH_HI;
            ST_PUSH_HI:    state_d = ST_PUSH_LO;
            ST_PUSH_LO:    state_d = ST_IDLE;
            ST_POP_LO:     state_d = ST_POP_HI;
            ST_POP_HI:     state_d = seq_is_rti_q ? ST_POP_FLAGS : ST_IDLE;
            ST_POP_FLAGS:  state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            irq_pending_q <= 1'b0;
            seq_is_int_q  <= 1'b0;
            seq_is_rti_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_pending_q <= irq_pending_d;
            seq_is_int_q  <= seq_is_int_d;
            seq_is_rti_q  <= seq_is_rti_d;
        end
    end

    // Output decode: Moore controls from the state register; stall also covers the accept cycle.
    always_comb begin
        memory_read             = 1'b0;
        memory_write            = 1'b0;
        memory_push             = 1'b0;
        memory_pop              = 1'b0;
        memory_write_src_select = WSRC_FLAGS;
        memory_address_select   = ADDR_STD;
        pc_choose_memory        = 1'b0;
        interrupt               = 1'b0;
        flags_restore           = 1'b0;
        done                    = 1'b0;
        stall                   = !idle || accept_start || accept_irq;
        case (state_q)
            ST_PUSH_FLAGS: begin
                memory_write            = 1'b1;
                memory_push             = 1'b1;
                memory_write_src_select = WSRC_FLAGS;
                memory_address_select   = ADDR_SP;
            end
            ST_PUSH_HI: begin
                memory_write            = 1'b1;
                memory_push             = 1'b1;
                memory_write_src_select = WSRC_PC_HI;
                memory_address_select   = ADDR_SP;
            end
            ST_PUSH_LO: begin
                memory_write            = 1'b1;
                memory_push             = 1'b1;
                memory_write_src_select = WSRC_PC_LO;
                memory_address_select   = ADDR_SP;
                interrupt               = seq_is_int_q;
                done                    = 1'b1;
            end
            ST_POP_LO: begin
                memory_read           = 1'b1;
                memory_pop            = 1'b1;
                memory_address_select = ADDR_SP;
            end
            ST_POP_HI: begin
                // The memory stage holds the full {upper, lower} PC word here.
                memory_read           = 1'b1;
                memory_pop            = 1'b1;
                memory_address_select = ADDR_SP;
                pc_choose_memory      = 1'b1;
                done                  = !seq_is_rti_q;
            end
            ST_POP_FLAGS: begin
                memory_read           = 1'b1;
                memory_pop            = 1'b1;
                memory_address_select = ADDR_SP;
                flags_restore         = 1'b1;
                done                  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: stimulus queues the hand-computed
// control vector for every stalled cycle; a negedge monitor pops and compares.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       irq = 1'b0;
    logic       memory_read, memory_write, memory_push, memory_pop;
    logic [1:0] memory_write_src_select, memory_address_select;
    logic       pc_choose_memory, interrupt, flags_restore, stall, done;

    int n_assert = 0;
    int n_fail   = 0;

    // {read, write, push, pop, src[1:0], addr[1:0], pcm, intr, frest, stall, done}
    localparam logic [12:0] V_ACC = 13'b0_0_0_0_00_00_0_0_0_1_0;
    localparam logic [12:0] V_PF  = 13'b0_1_1_0_00_10_0_0_0_1_0;
    localparam logic [12:0] V_PH  = 13'b0_1_1_0_01_10_0_0_0_1_0;
    localparam logic [12:0] V_PL  = 13'b0_1_1_0_10_10_0_0_0_1_1;
    localparam logic [12:0] V_PLI = 13'b0_1_1_0_10_10_0_1_0_1_1;
    localparam logic [12:0] V_RL  = 13'b1_0_0_1_00_10_0_0_0_1_0;
    localparam logic [12:0] V_RHR = 13'b1_0_0_1_00_10_1_0_0_1_1;
    localparam logic [12:0] V_RHI = 13'b1_0_0_1_00_10_1_0_0_1_0;
    localparam logic [12:0] V_RF  = 13'b1_0_0_1_00_10_0_0_1_1_1;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [12:0] act_vec;

    assign act_vec = {memory_read, memory_write, memory_push, memory_pop,
                      memory_write_src_select, memory_address_select,
                      pc_choose_memory, interrupt, flags_restore, stall, done};

    stack_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .op                      (op),
        .irq                     (irq),
        .memory_read             (memory_read),
        .memory_write            (memory_write),
        .memory_push             (memory_push),
        .memory_pop              (memory_pop),
        .memory_write_src_select (memory_write_src_select),
        .memory_address_select   (memory_address_select),
        .pc_choose_memory        (pc_choose_memory),
        .interrupt               (interrupt),
        .flags_restore           (flags_restore),
        .stall                   (stall),
        .done                    (done)
    );

    always #5 clk = ~clk;

    // Monitor: every stalled cycle must match the next queued vector;
    // every non-stalled cycle must show all controls at 0.
    always @(negedge clk) begin
        logic [12:0] e;
        string       t;
        n_assert++;
        if (act_vec[1]) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_busy: got %b required idle", act_vec);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (act_vec !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", t, act_vec, e);
                end else begin
                    $display("ok   %s: %b", t, act_vec);
                end
            end
        end else if (act_vec !== 13'd0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b required %b", act_vec, 13'd0);
        end
    end

    task automatic expect_v(input logic [12:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_assert++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        #1;
        check("reset_outputs", {19'd0, act_vec}, 32'd0);
        #21 reset = 1'b0;
        tick(2);

        // CALL: two push cycles, stall for three cycles, done in the second.
        expect_v(V_ACC, "call_accept"); expect_v(V_PH, "call_push_hi"); expect_v(V_PL, "call_push_lo");
        start = 1'b1; op = OP_CALL;
        tick(1);
        start = 1'b0; op = OP_NONE;
        drain("call");
        tick(2);

        // RET with an irq pulse in POP_LO: RET unchanged, INT follows immediately.
        expect_v(V_ACC, "ret_accept"); expect_v(V_RL, "ret_pop_lo"); expect_v(V_RHR, "ret_pop_hi");
        expect_v(V_ACC, "irq_accept"); expect_v(V_PF, "irq_push_flags");
        expect_v(V_PH, "irq_push_hi"); expect_v(V_PLI, "irq_push_lo");
        start = 1'b1; op = OP_RET;
        tick(1);
        start = 1'b0; op = OP_NONE; irq = 1'b1;
        tick(1);
        irq = 1'b0;
        drain("ret_irq");
        check("irq_pending_after_ret_irq", {31'd0, dut.irq_pending_q}, 32'd0);
        tick(2);

        // RTI, irq pulsed in POP_LO, start+CALL waiting at the idle boundary:
        // start wins, the pending irq runs after CALL's done.
        expect_v(V_ACC, "rti_accept"); expect_v(V_RL, "rti_pop_lo");
        expect_v(V_RHI, "rti_pop_hi"); expect_v(V_RF, "rti_pop_flags");
        expect_v(V_ACC, "prio_call_accept"); expect_v(V_PH, "prio_call_push_hi"); expect_v(V_PL, "prio_call_push_lo");
        expect_v(V_ACC, "prio_irq_accept"); expect_v(V_PF, "prio_irq_push_flags");
        expect_v(V_PH, "prio_irq_push_hi"); expect_v(V_PLI, "prio_irq_push_lo");
        start = 1'b1; op = OP_RTI;
        tick(1);
        start = 1'b0; op = OP_NONE; irq = 1'b1;
        tick(1);
        irq = 1'b0;
        tick(1);
        start = 1'b1; op = OP_CALL;
        tick(2);
        start = 1'b0; op = OP_NONE;
        drain("rti_prio");
        tick(2);

        // Illegal opcode and NONE: nothing happens (idle monitor checks stall/done).
        start = 1'b1; op = 3'd6;
        tick(1);
        check("illegal_op_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        op = OP_NONE;
        tick(1);
        check("none_op_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        start = 1'b0;
        tick(2);

        // start+INT with irq in the same cycle: exactly one INT.
        expect_v(V_ACC, "int_accept"); expect_v(V_PF, "int_push_flags");
        expect_v(V_PH, "int_push_hi"); expect_v(V_PLI, "int_push_lo");
        start = 1'b1; op = OP_INT; irq = 1'b1;
        tick(1);
        start = 1'b0; op = OP_NONE; irq = 1'b0;
        drain("int_irq");
        tick(3);
        check("irq_pending_after_int", {31'd0, dut.irq_pending_q}, 32'd0);

        // Back-to-back CALLs with start held by the stalled upstream.
        expect_v(V_ACC, "b2b1_accept"); expect_v(V_PH, "b2b1_push_hi"); expect_v(V_PL, "b2b1_push_lo");
        expect_v(V_ACC, "b2b2_accept"); expect_v(V_PH, "b2b2_push_hi"); expect_v(V_PL, "b2b2_push_lo");
        start = 1'b1; op = OP_CALL;
        tick(4);
        start = 1'b0; op = OP_NONE;
        drain("b2b");
        tick(2);

        // Reset in PUSH_HI of an INT with an irq latched mid-sequence.
        expect_v(V_ACC, "rst_int_accept"); expect_v(V_PF, "rst_int_push_flags"); expect_v(V_PH, "rst_int_push_hi");
        start = 1'b1; op = OP_INT;
        tick(1);
        start = 1'b0; op = OP_NONE; irq = 1'b1;
        tick(1);
        irq = 1'b0;
        check("irq_latched_before_reset", {31'd0, dut.irq_pending_q}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_outputs", {19'd0, act_vec}, 32'd0);
        check("reset_mid_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        check("reset_mid_irq_pending", {31'd0, dut.irq_pending_q}, 32'd0);
        check("reset_mid_seq_is_int", {31'd0, dut.seq_is_int_q}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick(4);
        check("post_reset_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        check("post_reset_irq_pending", {31'd0, dut.irq_pending_q}, 32'd0);
        drain("reset_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle control sequencer directly upstream of the memory stage. It turns one CALL, RET, INT or RTI request from the execute side into the per-cycle push/pop, write-source and address-select controls the memory stage consumes. While a sequence runs, it stalls the upstream pipeline. It also latches external interrupt requests and injects them as INT sequences at instruction boundaries.

## Interface
Parameters:
- none; all encodings come from `stack_seq_pkg`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request valid for one cycle, sampled only in IDLE.
- `op`  in  3  request opcode: NONE=0, CALL=1, RET=2, INT=3, RTI=4; codes 5–7 illegal.
- `irq`  in  1  external interrupt request, level or pulse.
- `memory_read`  out  1  memory stage read enable.
- `memory_write`  out  1  memory stage write enable.
- `memory_push`  out  1  write to stack, SP decrements.
- `memory_pop`  out  1  read stack at SP+1, SP increments.
- `memory_write_src_select`  out  2  00 flags, 01 PC[31:16], 10 PC[15:0], 11 register.
- `memory_address_select`  out  2  10 (SP) during any sequence, else 00.
- `pc_choose_memory`  out  1  next PC taken from the popped 32-bit word.
- `interrupt`  out  1  forces next PC to 0.
- `flags_restore`  out  1  write popped word [2:0] to the flag register.
- `stall`  out  1  hold fetch/decode/execute.
- `done`  out  1  one-cycle pulse in the last sequence cycle.

## Operation
- States: IDLE, PUSH_FLAGS, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_FLAGS.
- Moore outputs decoded from the state register only, except `stall`.
- `stall` = (state != IDLE) | (IDLE & accept). Accept means `start` with a legal non-NONE op, or pending irq.
- Sequences, one state per cycle, starting the cycle after accept:
  - CALL: PUSH_HI → PUSH_LO → IDLE.
  - INT: PUSH_FLAGS → PUSH_HI → PUSH_LO → IDLE.
  - RET: POP_LO → POP_HI → IDLE.
  - RTI: POP_LO → POP_HI → POP_FLAGS → IDLE.
- Push states: `memory_write`=1, `memory_push`=1, `memory_address_select`=10.
  - `memory_write_src_select`: PUSH_FLAGS 00, PUSH_HI 01, PUSH_LO 10.
- Pop states: `memory_read`=1, `memory_pop`=1, `memory_address_select`=10.
- `pc_choose_memory`=1 only in POP_HI. The memory stage's shift register holds {upper, lower} in that cycle.
- `interrupt`=1 only in PUSH_LO of an INT sequence. `flags_restore`=1 only in POP_FLAGS.
- `done`=1 in the final state of each sequence (PUSH_LO, POP_HI for RET, POP_FLAGS).
- `irq_pending` register:
  - Set on any cycle with `irq`=1.
  - Cleared on the cycle the INT sequence is accepted from it.
- Priority in IDLE: `start` beats pending irq. The irq stays pending and is taken in the first IDLE cycle after that sequence's `done`.
- `start` with `op`=INT uses the same INT sequence and also clears `irq_pending`. One INT serves both.
- `start` while not IDLE is ignored. Upstream is stalled, so this does not occur legally.
- Illegal op or NONE: no transition, no `done`, `stall`=0.
- Distinguishing INT from CALL in PUSH_HI/PUSH_LO: a 1-bit `seq_is_int` register, captured on accept. RET vs RTI uses `seq_is_rti` likewise.

## Timing
- Reset (asynchronous, any time including mid-sequence):
  - State → IDLE; `irq_pending`, `seq_is_int`, `seq_is_rti` → 0.
  - All outputs 0 immediately. `memory_address_select` 00, `memory_write_src_select` 00.
- Latency: accept at edge N. First memory cycle is N+1. `done` at N+2 (CALL, RET) or N+3 (INT, RTI).
- Back-to-back: a new `start` is sampled in the cycle after `done`, when the state is IDLE. Minimum gap is 0 idle cycles between sequences only if `start` is held high by the stalled upstream.
- `irq` arriving in the same cycle as a `done` is latched. It is taken in the following IDLE cycle.

## Structure
- `stack_seq_pkg` holds:
  - opcode enum
  - state enum
  - write-source constants (FLAGS, PC_HI, PC_LO, REG)
  - address-select constants (STD, LDD, SP)
- The memory stage imports the same constants.
- Single module: one state register plus next-state logic, and one output decode block. No sub-module.

## Test plan
- Reset mid-INT (in PUSH_HI) → all outputs 0 in the same cycle; IDLE after release; `irq_pending`=0.
- `start`,CALL → push controls for 2 cycles:
  - src 01 then 10; `stall` 1 for 3 cycles; `done` in cycle 2.
  - `interrupt` and `pc_choose_memory` stay 0.
- `start`,RTI → 3 pop cycles; `pc_choose_memory`=1 only in cycle 2; `flags_restore`=1 only in cycle 3.
- `irq` pulse during a RET sequence → RET completes unchanged. INT starts the next cycle with src order 00, 01, 10. `interrupt`=1 in its third cycle.
- `start`,op=6 → no state change, `stall`=0, `done` never asserted.
- `start`,INT with `irq` high the same cycle → exactly one INT sequence; `irq_pending` 0 afterward.
